// File: rtl/dw_lod_sched.sv
// ---------------------------------------------------------------------------
// dw_lod_sched
//   Leading-one-detect request scheduler. Single-cycle request pulses are
//   latched into a pending vector; the highest set bit (MSB = highest
//   priority) of the selection vector is granted. The grant is registered
//   and held until the consumer acknowledges it. The grant is reported both
//   one-hot and as a leading-zero count.
//
//   Optional feature: define DW_LOD_SCHED_RR_EN to add a round-robin mask.
//   The mask makes selection rotate downward from the last granted bit.
//   Without the macro, selection is strict fixed priority.
//
// Parameters
//   req_width : number of requesters (2..256)
//   enc_width : encoded grant width, ceil(log2(req_width))+1
//
// Ports
//   clk       in  : clock, rising edge
//   rst_n     in  : asynchronous active-low reset
//   req_in    in  : request pulses, bit i sets pend[i]
//   clr       in  : synchronous flush of pending requests and active grant
//   gnt_ack   in  : consumer accepts current grant (ignored when idle)
//   gnt_valid out : grant active
//   gnt_dec   out : one-hot grant
//   gnt_enc   out : leading-zero count of gnt_dec (bit i -> req_width-1-i)
//   pend      out : pending-request register
//   busy      out : gnt_valid | (pend != 0), combinational from registers
// ---------------------------------------------------------------------------
module dw_lod_sched #(
    parameter int req_width = 8,
    parameter int enc_width = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [req_width-1:0] req_in,
    input  logic                 clr,
    input  logic                 gnt_ack,
    output logic                 gnt_valid,
    output logic [req_width-1:0] gnt_dec,
    output logic [enc_width-1:0] gnt_enc,
    output logic [req_width-1:0] pend,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [req_width-1:0] ONE = req_width'(1);

    state_t                 r_state, w_state_nxt;
    logic                   r_gnt_valid, w_gnt_valid_nxt;
    logic [req_width-1:0]   r_gnt_dec, w_gnt_dec_nxt;
    logic [enc_width-1:0]   r_gnt_enc, w_gnt_enc_nxt;
    logic [req_width-1:0]   r_pend, w_pend_nxt;
    logic [req_width-1:0]   w_ack_clear;
    logic [req_width-1:0]   w_sel;
    logic [req_width-1:0]   w_lod_dec;
    logic [enc_width-1:0]   w_lod_enc;

`ifdef DW_LOD_SCHED_RR_EN
    logic [req_width-1:0]   r_mask, w_mask_nxt;
    logic [req_width-1:0]   w_masked;

    // Prefer requests below the last granted bit; fall back to the full
    // pending vector once that window is empty so the search wraps to the MSB.
    assign w_masked = r_pend & r_mask;
    assign w_sel    = (|w_masked) ? w_masked : r_pend;
`else
    assign w_sel    = r_pend;
`endif

    // Leading-one detector: ascending scan, so the highest set bit is the
    // last assignment and wins.
    always_comb begin
        w_lod_dec = '0;
        w_lod_enc = '0;
        for (int i = 0; i < req_width; i++) begin
            if (w_sel[i]) begin
                w_lod_dec    = '0;
                w_lod_dec[i] = 1'b1;
                w_lod_enc    = enc_width'(req_width - 1 - i);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_dec_nxt   = r_gnt_dec;
        w_gnt_enc_nxt   = r_gnt_enc;
        w_ack_clear     = '0;
`ifdef DW_LOD_SCHED_RR_EN
        w_mask_nxt      = r_mask;
`endif
        if (clr) begin
            w_state_nxt     = IDLE;
            w_gnt_valid_nxt = 1'b0;
            w_gnt_dec_nxt   = '0;
            w_gnt_enc_nxt   = '0;
`ifdef DW_LOD_SCHED_RR_EN
            w_mask_nxt      = '1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_sel) begin
                        w_state_nxt     = GRANT;
                        w_gnt_valid_nxt = 1'b1;
                        w_gnt_dec_nxt   = w_lod_dec;
                        w_gnt_enc_nxt   = w_lod_enc;
                    end
                end
                GRANT: begin
                    if (gnt_ack) begin
                        w_ack_clear     = r_gnt_dec;
                        w_state_nxt     = IDLE;
                        w_gnt_valid_nxt = 1'b0;
                        w_gnt_dec_nxt   = '0;
                        w_gnt_enc_nxt   = '0;
`ifdef DW_LOD_SCHED_RR_EN
                        // one-hot minus one gives all bits below the grant;
                        // granting bit 0 reopens the whole vector
                        w_mask_nxt = (r_gnt_dec == ONE) ? '1 : (r_gnt_dec - ONE);
`endif
                    end
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_gnt_valid_nxt = 1'b0;
                    w_gnt_dec_nxt   = '0;
                    w_gnt_enc_nxt   = '0;
                end
            endcase
        end
    end

    // A request on the bit being acked in the same cycle survives (set wins)
    assign w_pend_nxt = clr ? '0 : ((r_pend & ~w_ack_clear) | req_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt_dec   <= '0;
            r_gnt_enc   <= '0;
            r_pend      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt_dec   <= w_gnt_dec_nxt;
            r_gnt_enc   <= w_gnt_enc_nxt;
            r_pend      <= w_pend_nxt;
        end
    end

`ifdef DW_LOD_SCHED_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '1;
        end else begin
            r_mask <= w_mask_nxt;
        end
    end
`endif

    assign gnt_valid = r_gnt_valid;
    assign gnt_dec   = r_gnt_dec;
    assign gnt_enc   = r_gnt_enc;
    assign pend      = r_pend;
    assign busy      = r_gnt_valid | (|r_pend);

endmodule

// File: tb/tb_dw_lod_sched.sv
module tb_dw_lod_sched;

    localparam int RW = 8;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] req_in = '0;
    logic          clr = 1'b0;
    logic          gnt_ack = 1'b0;
    logic          gnt_valid;
    logic [RW-1:0] gnt_dec;
    logic [EW-1:0] gnt_enc;
    logic [RW-1:0] pend;
    logic          busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [RW-1:0] dec;
        logic [EW-1:0] enc;
    } gnt_t;

    gnt_t exp_q[$];

    dw_lod_sched #(.req_width(RW), .enc_width(EW)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr(clr),
        .gnt_ack(gnt_ack), .gnt_valid(gnt_valid), .gnt_dec(gnt_dec),
        .gnt_enc(gnt_enc), .pend(pend), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [RW-1:0] d, input logic [EW-1:0] e);
        gnt_t g;
        g.dec = d;
        g.enc = e;
        exp_q.push_back(g);
    endtask

    // Wait (bounded) for a grant, then ack it for exactly one cycle
    task automatic ack_now(input string nm);
        for (int n = 0; n < 20 && !gnt_valid; n++) cyc();
        if (!gnt_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout got gnt_valid=0 expected 1", nm);
        end
        gnt_ack = 1'b1;
        cyc();
        gnt_ack = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_pend"}, 32'(pend), 0);
        chk({nm, "_gv"},   32'(gnt_valid), 0);
        chk({nm, "_dec"},  32'(gnt_dec), 0);
        chk({nm, "_enc"},  32'(gnt_enc), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
    endtask

    // Scoreboard monitor: every new grant pops one expectation; a held grant
    // must not change while gnt_valid stays high.
    logic          prev_gv = 1'b0;
    logic [RW-1:0] held_dec = '0;
    logic [EW-1:0] held_enc = '0;
    always @(negedge clk) begin
        if (gnt_valid && !prev_gv) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got grant 0x%0h expected none", gnt_dec);
            end else begin
                gnt_t g;
                g = exp_q.pop_front();
                chk("mon_dec", 32'(gnt_dec), 32'(g.dec));
                chk("mon_enc", 32'(gnt_enc), 32'(g.enc));
            end
        end else if (gnt_valid && prev_gv) begin
            chk("mon_hold_dec", 32'(gnt_dec), 32'(held_dec));
            chk("mon_hold_enc", 32'(gnt_enc), 32'(held_enc));
        end
        prev_gv  = gnt_valid;
        held_dec = gnt_dec;
        held_enc = gnt_enc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset and idle
        cyc(); cyc();
        chk_idle("rst");
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk_idle("idle");
        end

        // 2: two requests, immediate ack
        req_in = 8'h24;
        push(8'h20, 4'd2);
        push(8'h04, 4'd5);
        cyc();
        req_in = '0;
        chk("s2_pend", 32'(pend), 32'h24);
        chk("s2_gv0", 32'(gnt_valid), 0);
        cyc();
        chk("s2_gv1", 32'(gnt_valid), 1);
        gnt_ack = 1'b1;
        cyc();
        gnt_ack = 1'b0;
        chk("s2_gv_drop", 32'(gnt_valid), 0);
        chk("s2_pend2", 32'(pend), 32'h04);
        cyc();
        chk("s2_gv2", 32'(gnt_valid), 1);
        gnt_ack = 1'b1;
        cyc();
        gnt_ack = 1'b0;
        chk("s2_pend_end", 32'(pend), 0);
        chk("s2_busy_end", 32'(busy), 0);

        // 3: held grant with a higher request arriving mid-hold
        clr = 1'b1; cyc(); clr = 1'b0;
        req_in = 8'h24;
        push(8'h20, 4'd2);
        cyc();
        req_in = '0;
        cyc();
        for (int k = 0; k < 10; k++) begin
            chk("s3_hold_gv", 32'(gnt_valid), 1);
            chk("s3_hold_dec", 32'(gnt_dec), 32'h20);
            req_in = (k == 4) ? 8'h80 : 8'h00;
            cyc();
        end
        req_in = '0;
        chk("s3_pend", 32'(pend), 32'hA4);
`ifdef DW_LOD_SCHED_RR_EN
        push(8'h04, 4'd5);
        push(8'h80, 4'd0);
`else
        push(8'h80, 4'd0);
        push(8'h04, 4'd5);
`endif
        gnt_ack = 1'b1;
        cyc();
        gnt_ack = 1'b0;
        chk("s3_gv_drop", 32'(gnt_valid), 0);
        ack_now("s3_g2");
        ack_now("s3_g3");
        chk("s3_pend_end", 32'(pend), 0);

        // 4: ack and re-request of the same bit in one cycle
        clr = 1'b1; cyc(); clr = 1'b0;
        req_in = 8'h10;
        push(8'h10, 4'd3);
        push(8'h10, 4'd3);
        cyc();
        req_in = '0;
        cyc();
        chk("s4_gv1", 32'(gnt_valid), 1);
        gnt_ack = 1'b1;
        req_in = 8'h10;
        cyc();
        gnt_ack = 1'b0;
        req_in = '0;
        chk("s4_gv_drop", 32'(gnt_valid), 0);
        chk("s4_pend", 32'(pend), 32'h10);
        cyc();
        chk("s4_gv2", 32'(gnt_valid), 1);
        ack_now("s4_g2");
        chk("s4_pend_end", 32'(pend), 0);

        // 5: clr beats ack and req_in
        clr = 1'b1; cyc(); clr = 1'b0;
        req_in = 8'hFF;
        push(8'h80, 4'd0);
        cyc();
        req_in = '0;
        cyc();
        chk("s5_pend", 32'(pend), 32'hFF);
        chk("s5_gv", 32'(gnt_valid), 1);
        clr = 1'b1;
        gnt_ack = 1'b1;
        req_in = 8'h01;
        cyc();
        clr = 1'b0;
        gnt_ack = 1'b0;
        req_in = '0;
        chk_idle("s5_clr");
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("s5_no_gnt", 32'(gnt_valid), 0);
        end

        // 6: asynchronous reset mid-grant
        req_in = 8'h0C;
        push(8'h08, 4'd4);
        cyc();
        req_in = '0;
        cyc();
        chk("s6_pend", 32'(pend), 32'h0C);
        chk("s6_gv", 32'(gnt_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk_idle("s6_async");
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("s6_after", 32'(gnt_valid), 0);
        end

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dw_lod_sched.md
# dw_lod_sched

Leading-one-detect request scheduler: latches single-cycle request pulses into a pending vector, picks one pending request with a leading-one detector (MSB = highest priority), and issues a registered grant held until acknowledged. Sits in front of a shared datapath resource owned by several requesters and serialises access with a valid/ack handshake. The grant is given both as a one-hot vector and as a leading-zero-count encoding.

## Interface
- `req_width`, default 8: number of requesters, legal range 2..256.
- `enc_width`, default 4: encoded grant width; must equal ceil(log2(req_width))+1.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_in` in req_width: a 1 on bit i for one cycle sets `pend[i]`.
- `clr` in 1: synchronous flush of all pending requests and any active grant.
- `gnt_ack` in 1: consumer accepts the current grant; ignored when `gnt_valid`=0.
- `gnt_valid` out 1: grant active.
- `gnt_dec` out req_width: one-hot grant, the leading one of the selected vector.
- `gnt_enc` out enc_width: leading-zero count of `gnt_dec`, so bit i gives req_width-1-i.
- `pend` out req_width: pending-request register.
- `busy` out 1: `gnt_valid` OR (`pend` != 0).

## Operation
- FSM states: IDLE and GRANT. Reset state is IDLE.
- IDLE:
  - If the selection vector is nonzero, register `gnt_dec`/`gnt_enc` from its leading one, set `gnt_valid`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `gnt_valid`, `gnt_dec` and `gnt_enc` are held stable until `gnt_ack`=1 is sampled.
  - On ack: clear the granted `pend` bit, drop `gnt_valid`, zero `gnt_dec`/`gnt_enc`, return to IDLE.
- Selection vector: `pend` (see Configuration for masking).
- `pend` update each edge, in priority order:
  - `clr` zeroes it.
  - Otherwise: next = (pend & ~ack_clear) | req_in. Set wins when the same bit is acked and requested in one cycle, so the bit stays pending and is granted again.
- `req_in` bits already pending are absorbed; there is no counting of repeated requests.
- `clr`:
  - Has priority over `req_in` and `gnt_ack`.
  - Forces IDLE, `gnt_valid`=0, `gnt_dec`=0, `gnt_enc`=0.
  - Resets the round-robin mask when present.
- Reset values: `pend`=0, `gnt_valid`=0, `gnt_dec`=0, `gnt_enc`=0, `busy`=0, FSM=IDLE, mask=all ones.
- Asserting `rst_n` low mid-grant aborts the grant immediately (asynchronous). No ack is expected afterwards.

## Timing
- All outputs are registered except `busy`, which is combinational from registers.
- `req_in` sampled at edge E0 → `pend` set after E0 → grant registered at E1 → `gnt_valid` high one cycle after the request cycle.
- `gnt_ack` sampled at edge Ea → `gnt_valid` low after Ea → next grant registered at Ea+1 at the earliest.
- Maximum throughput is one grant per 2 cycles with immediate ack.
- `gnt_ack` while `gnt_valid`=0 has no effect.

## Configuration
- Macro: `DW_LOD_SCHED_RR_EN`.
- Defined: adds a req_width mask register, reset value all ones.
  - Selection = `pend & mask` if that is nonzero, else `pend`.
  - On ack of bit i, mask becomes bits i-1..0 set and the rest clear; if i=0, mask becomes all ones.
  - Result: round-robin descending from the MSB, with no starvation.
- Undefined: no mask register; selection = `pend`; strict fixed priority with the MSB highest.
- Handshake and latency are identical in both builds.

## Test plan
All scenarios use req_width=8, enc_width=4.

1. Reset, then idle 5 cycles with no requests → `pend`=0, `gnt_valid`=0, `gnt_dec`=0, `gnt_enc`=0, `busy`=0 throughout.
2. `req_in`=0x24 for one cycle, ack each grant the cycle it appears → first grant `gnt_dec`=0x20, `gnt_enc`=2; second grant 0x04, `gnt_enc`=5 two cycles later; then `pend`=0 and `busy`=0.
3. `req_in`=0x24, hold ack low 10 cycles, pulse `req_in`=0x80 mid-hold → grant stays 0x20/2 for all 10 cycles. After ack:
   - Fixed-priority build: next grant 0x80/0, then 0x04/5.
   - RR build: next grant 0x04/5 (mask 0x1F), then 0x80/0.
4. During grant 0x10, assert `gnt_ack` and `req_in`=0x10 in the same cycle → `pend[4]` stays 1; 0x10/3 is granted again two cycles later.
5. `pend`=0xFF with grant 0x80 active, pulse `clr` together with `gnt_ack` and `req_in`=0x01 → next cycle `pend`=0, `gnt_valid`=0, `busy`=0; no further grant.
6. Drop `rst_n` asynchronously mid-grant with `pend`=0x0C → outputs return to reset values before the next edge. After release with no requests, `gnt_valid` stays 0.
